// File: rtl/band_queue_if.sv
// Stereo sample bus between the producer, band_queue and the downstream FIR.
interface band_queue_if;
  logic        valid;
  logic [15:0] lft_in;
  logic [15:0] rght_in;
  logic        sequencing;
  logic [15:0] lft_out;
  logic [15:0] rght_out;

  modport master (
    output valid, lft_in, rght_in,
    input  sequencing, lft_out, rght_out
  );

  modport slave (
    input  valid, lft_in, rght_in,
    output sequencing, lft_out, rght_out
  );
endinterface

// File: rtl/band_queue.sv
// Stereo sample queue that streams the latest RD_LEN samples to a FIR on every new sample.
// Optional BAND_QUEUE_OVERRUN_EN adds a sticky overrun_o flag for samples arriving mid-burst.
module band_queue #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RD_LEN = 1021
) (
  input  logic           clk,
  input  logic           rst_n,
`ifdef BAND_QUEUE_OVERRUN_EN
  output logic           overrun_o,
`endif
  band_queue_if.slave    bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(RD_LEN + 1);
  localparam logic [AW-1:0] RdBack = AW'(RD_LEN - 1);

  typedef enum logic [1:0] {StFill, StIdle, StRead} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   new_ptr_q, new_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   fill_cnt_q, fill_cnt_d;
  logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
  logic            pend_q, pend_d;
  logic            rd_vld_q;
  logic            seq_q;
  logic [15:0]     lft_q, rght_q;
  logic [15:0]     rd_l_q, rd_r_q;
  logic [AW-1:0]   start_ptr;
  logic            rd_en;
  logic            last_rd;

  logic [15:0] mem_l [DEPTH];
  logic [15:0] mem_r [DEPTH];

  assign rd_en     = (state_q == StRead);
  assign last_rd   = rd_en && (rd_cnt_q == CW'(RD_LEN - 1));
  assign start_ptr = new_ptr_q - RdBack;

  // Read-before-write: a same-address write in this cycle is not seen by the read.
  always_ff @(posedge clk) begin
    if (bus.valid) begin
      mem_l[new_ptr_q] <= bus.lft_in;
      mem_r[new_ptr_q] <= bus.rght_in;
    end
    if (rd_en) begin
      rd_l_q <= mem_l[rd_ptr_q];
      rd_r_q <= mem_r[rd_ptr_q];
    end
  end

  always_comb begin
    state_d    = state_q;
    new_ptr_d  = new_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_cnt_d = fill_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    pend_d     = pend_q;

    if (bus.valid) begin
      new_ptr_d = new_ptr_q + 1'b1;
      if (fill_cnt_q != CW'(RD_LEN)) begin
        fill_cnt_d = fill_cnt_q + 1'b1;
      end
    end

    case (state_q)
      StFill: begin
        if (bus.valid && (fill_cnt_q == CW'(RD_LEN - 1))) begin
          state_d  = StRead;
          rd_ptr_d = start_ptr;
          rd_cnt_d = '0;
        end
      end
      StIdle: begin
        // pend_q: a sample landed on the last read of the previous burst; one idle
        // cycle here separates the two bursts on the sequencing output.
        if (pend_q) begin
          state_d  = StRead;
          rd_cnt_d = '0;
          pend_d   = 1'b0;
        end else if (bus.valid) begin
          state_d  = StRead;
          rd_ptr_d = start_ptr;
          rd_cnt_d = '0;
        end
      end
      StRead: begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (last_rd) begin
          state_d = StIdle;
          if (bus.valid) begin
            rd_ptr_d = start_ptr;
            pend_d   = 1'b1;
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFill;
      new_ptr_q  <= '0;
      rd_ptr_q   <= '0;
      fill_cnt_q <= '0;
      rd_cnt_q   <= '0;
      pend_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
      seq_q      <= 1'b0;
      lft_q      <= '0;
      rght_q     <= '0;
    end else begin
      state_q    <= state_d;
      new_ptr_q  <= new_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      pend_q     <= pend_d;
      rd_vld_q   <= rd_en;
      seq_q      <= rd_vld_q;
      lft_q      <= rd_vld_q ? rd_l_q : 16'h0000;
      rght_q     <= rd_vld_q ? rd_r_q : 16'h0000;
    end
  end

  assign bus.sequencing = seq_q;
  assign bus.lft_out    = lft_q;
  assign bus.rght_out   = rght_q;

`ifdef BAND_QUEUE_OVERRUN_EN
  logic overrun_q;
  logic ovr_set;

  // Any sample accepted while a readout is in flight, including the pending idle cycle.
  assign ovr_set = bus.valid && ((rd_en && !last_rd) || ((state_q == StIdle) && pend_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (ovr_set) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun_o = overrun_q;
`endif

endmodule
